// File: rtl/seq_sub_divider.sv
// seq_sub_divider
//   Iterative unsigned restoring divider for the F_Div mantissa path.
//   One shift-and-trial-subtract step per clock produces one quotient bit,
//   MSB first, so a non-zero-divisor result is ready WIDTH cycles after the
//   operands are accepted. A zero divisor short-circuits straight to DONE.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start_vld    operands valid
//   start_rdy    operands can be accepted (IDLE only)
//   dividend     unsigned numerator, sampled on accept
//   divisor      unsigned denominator, sampled on accept
//   res_vld      result valid (DONE only)
//   res_rdy      consumer takes the result
//   quotient     floor(dividend / divisor), all ones on divide-by-zero
//   remainder    dividend mod divisor, dividend on divide-by-zero
//   div_by_zero  held result came from a zero divisor
//   busy         iterating (CALC)
module seq_sub_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_vld,
  output logic             start_rdy,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  // The working remainder is always below the divisor, so its top bit of the
  // WIDTH+1 trial is never set after a step and need not be stored.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             start_rdy_q, res_vld_q, busy_q;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvsr_q};
    if (trial_s[WIDTH] == 1'b0) begin
      step_rem_s = trial_s[WIDTH-1:0];
      step_quo_s = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem_s = shifted_s[WIDTH-1:0];
      step_quo_s = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start_vld) begin
          if (divisor != {WIDTH{1'b0}}) begin
            dvsr_d  = divisor;
            quo_d   = dividend;
            rem_d   = {WIDTH{1'b0}};
            cnt_d   = CNT_INIT;
            state_d = S_CALC;
          end else begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        quo_d = step_quo_s;
        rem_d = step_rem_s;
        cnt_d = cnt_q - CNT_ONE;
        // Last step: publish the freshly computed bits on the same edge.
        if (cnt_q == CNT_ONE) begin
          quotient_d  = step_quo_s;
          remainder_d = step_rem_s;
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (res_rdy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      dvsr_q      <= {WIDTH{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      start_rdy_q <= 1'b1;
      res_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      start_rdy_q <= (state_d == S_IDLE);
      res_vld_q   <= (state_d == S_DONE);
      busy_q      <= (state_d == S_CALC);
    end
  end

  assign start_rdy   = start_rdy_q;
  assign res_vld     = res_vld_q;
  assign busy        = busy_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_sub_divider.sv
// Self-checking bench for seq_sub_divider (WIDTH=64): directed cases plus a
// randomized sweep; results are checked by a scoreboard monitor against a
// plain-arithmetic reference.
module tb_seq_sub_divider;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_vld;
  logic         start_rdy;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         res_vld;
  logic         res_rdy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_sub_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_vld  (start_vld),
    .start_rdy  (start_rdy),
    .dividend   (dividend),
    .divisor    (divisor),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and flags sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns the cycle stamp of the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, output int acc_cyc);
    int guard;
    start_vld = 1'b1;
    dividend  = a;
    divisor   = b;
    guard     = 0;
    while (!start_rdy && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) chk("accept_timeout", 64'(guard), 64'd0);
    if (push) sb.push_back(model(a, b));
    tick();
    acc_cyc   = cyc;
    start_vld = 1'b0;
  endtask

  // Count edges after accept until res_vld, and how many of those saw busy.
  task automatic wait_result(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!res_vld && lat < 300) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  // Scoreboard monitor: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && res_vld && res_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=q:%h r:%h required=none", quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_quotient", quotient, mon_e.q);
        chk("sb_remainder", remainder, mon_e.r);
        chk("sb_div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, lat, bc, h, sel;
    logic [W-1:0] a, b;

    rst = 1'b1; start_vld = 1'b0; res_rdy = 1'b1; dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst_start_rdy", 64'(start_rdy), 64'd1);
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);
    rst = 1'b0;
    tick();

    // Basic division and exact latency.
    issue(64'd100, 64'd7, 1'b1, acc1);
    wait_result(lat, bc);
    chk("basic_latency", 64'(lat), 64'(W));
    chk("basic_busy_cycles", 64'(bc), 64'(W));
    tick();

    // Divide by zero: result right after the accept edge, never busy.
    issue(64'h1234, 64'd0, 1'b1, acc1);
    chk("dbz_busy", 64'(busy), 64'd0);
    wait_result(lat, bc);
    chk("dbz_latency", 64'(lat), 64'd0);
    chk("dbz_busy_cycles", 64'(bc), 64'd0);
    tick();

    // Extremes.
    issue('1, 64'd1, 1'b1, acc1);
    wait_result(lat, bc);
    tick();
    issue('1, '1, 1'b1, acc1);
    wait_result(lat, bc);
    tick();
    issue(64'd77, 64'd77, 1'b1, acc1);
    wait_result(lat, bc);
    tick();

    // Backpressure: 5/9 held for 10 cycles.
    res_rdy = 1'b0;
    issue(64'd5, 64'd9, 1'b1, acc1);
    wait_result(lat, bc);
    chk("bp_latency", 64'(lat), 64'(W));
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_vld", 64'(res_vld), 64'd1);
      chk("bp_quotient", quotient, 64'd0);
      chk("bp_remainder", remainder, 64'd5);
      tick();
    end
    res_rdy = 1'b1;
    tick();
    chk("bp_release_res_vld", 64'(res_vld), 64'd0);
    chk("bp_release_start_rdy", 64'(start_rdy), 64'd1);

    // Handshake gating: operands churn while the block is occupied.
    issue(64'd123456789, 64'd1000, 1'b1, acc1);
    start_vld = 1'b1;
    h = 0;
    while (!start_rdy && h < 300) begin
      chk("gate_occupied", 64'(busy | res_vld), 64'd1);
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      tick();
      h++;
    end
    issue(64'd1000, 64'd7, 1'b1, acc2);
    chk("gate_spacing", 64'(acc2 - acc1), 64'(W + 2));
    wait_result(lat, bc);
    chk("gate_latency", 64'(lat), 64'(W));
    tick();

    // Reset at iteration 30 of 1000/3 discards the operation.
    issue(64'd1000, 64'd3, 1'b0, acc1);
    repeat (29) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_start_rdy", 64'(start_rdy), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_res_vld", 64'(res_vld), 64'd0);
    chk("midrst_quotient", quotient, 64'd0);
    chk("midrst_remainder", remainder, 64'd0);
    issue(64'd1000, 64'd3, 1'b1, acc1);
    wait_result(lat, bc);
    chk("postrst_latency", 64'(lat), 64'(W));
    chk("postrst_quotient", quotient, 64'd333);
    chk("postrst_remainder", remainder, 64'd1);
    tick();

    // Randomized sweep with mixed operand classes and random backpressure.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 19);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (sel)
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4:       b = 64'd1;
        5, 6:    begin b = b | 64'd1; a = a % b; end
        7:       a = '1;
        8:       a = b;
        default: b = (b >> $urandom_range(0, 62)) | 64'd1;
      endcase
      h = $urandom_range(0, 3);
      res_rdy = (h == 0);
      issue(a, b, 1'b1, acc1);
      wait_result(lat, bc);
      chk("rand_latency", 64'(lat), (b == '0) ? 64'd0 : 64'(W));
      if (!res_rdy) begin
        repeat (h) tick();
        res_rdy = 1'b1;
      end
      tick();
    end

    repeat (4) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
